// File: rtl/ser_load_ctrl_if.sv
// Serial preload link (sck/sdi/cs_n) and the parallel load/status signals of ser_load_ctrl.
// The master drives the serial pins; the slave is the controller, which drives the load and status signals.
interface ser_load_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             sck;
    logic             sdi;
    logic             cs_n;
    logic [WIDTH-1:0] load_val;
    logic             load_stb;
    logic             busy;
    logic             frame_err;

    modport master (
        output sck, sdi, cs_n,
        input  load_val, load_stb, busy, frame_err
    );

    modport slave (
        input  sck, sdi, cs_n,
        output load_val, load_stb, busy, frame_err
    );
endinterface

// File: rtl/ser_load_ctrl.sv
// Serial preload receiver: synchronises a 3-wire link into clk, assembles MSB-first frames
// and hands each good frame to the counter's parallel load port as a one-cycle strobe.
//
// state | meaning
// IDLE  | waiting for cs_n to fall
// SHIFT | collecting bits on synchronised sck rising edges
// HOLD  | full frame held, waiting for cs_n to rise to commit it
// ERR   | overrun seen, waiting for cs_n to rise
module ser_load_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    ser_load_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, ERR} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, cs_sr;
    logic                   sck_q, cs_q;
    logic                   sck_sync, sdi_sync, cs_sync;
    logic                   sck_rise, cs_fall, cs_rise;

    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [WIDTH-1:0] load_val_q, load_val_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt, cnt_inc;
    logic             stb_q, stb_nxt;
    logic             busy_q, busy_nxt;
    logic             err_q, err_nxt;

    assign sck_sync = sck_sr[SYNC_STAGES-1];
    assign sdi_sync = sdi_sr[SYNC_STAGES-1];
    assign cs_sync  = cs_sr[SYNC_STAGES-1];

    assign sck_rise = sck_sync & ~sck_q;
    assign cs_fall  = ~cs_sync & cs_q;
    assign cs_rise  = cs_sync & ~cs_q;

    assign cnt_inc  = cnt_q + 1'b1;

    // Idle levels (sck/cs_n high) so that releasing reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr <= '1;
            cs_sr  <= '1;
            sdi_sr <= '0;
            sck_q  <= 1'b1;
            cs_q   <= 1'b1;
        end else begin
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], bus.sck};
            cs_sr  <= {cs_sr[SYNC_STAGES-2:0], bus.cs_n};
            sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], bus.sdi};
            sck_q  <= sck_sync;
            cs_q   <= cs_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            load_val_q <= '0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            cnt_q      <= cnt_nxt;
            load_val_q <= load_val_nxt;
            stb_q      <= stb_nxt;
            busy_q     <= busy_nxt;
            err_q      <= err_nxt;
        end
    end

    // cs_rise is tested before sck_rise everywhere so a coincident sck edge is dropped
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        cnt_nxt      = cnt_q;
        load_val_nxt = load_val_q;
        stb_nxt      = 1'b0;
        err_nxt      = err_q;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (sck_rise) begin
                        shift_nxt = {shift_q[WIDTH-2:0], sdi_sync};
                        cnt_nxt   = cnt_inc;
                        if (cnt_inc == CNT_FULL) state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        load_val_nxt = shift_q;
                        stb_nxt      = 1'b1;
                        state_nxt    = IDLE;
                    end else if (sck_rise) begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end
                ERR: begin
                    if (cs_rise) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt == SHIFT) || (state_nxt == HOLD);
    end

    assign bus.load_val  = load_val_q;
    assign bus.load_stb  = stb_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ser_load_ctrl.sv
// Bench for ser_load_ctrl: a table of serial frames plus hand-written reset sequences;
// expected load values are queued as frames are driven and consumed on each load_stb.
module tb_ser_load_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    ser_load_ctrl_if #(.WIDTH(WIDTH)) bus ();

    ser_load_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_lv;
    logic             prev_stb = 1'b0;

    typedef struct {
        int          nbits;
        logic [15:0] data;
        int          ena_drop;
        int          gap;
        logic        exp_load;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued frame and last one cycle
    always @(negedge clk) begin
        if (rst_n && bus.load_stb) begin
            if (exp_q.size() == 0) begin
                check("unexpected_stb", 16'(bus.load_val), 16'hFFFF);
            end else begin
                check("stb_load_val", 16'(bus.load_val), 16'(exp_q.pop_front()));
            end
            if (prev_stb) check("stb_width", 16'd2, 16'd1);
        end
        prev_stb = rst_n && bus.load_stb;
    end

    task automatic send_frame(input int n, input logic [15:0] d, input int ena_drop,
                              input logic good, input logic [WIDTH-1:0] val);
        bus.cs_n = 1'b0;
        repeat (10) @(negedge clk);
        check("err_clear_at_cs_fall", 16'(bus.frame_err), 16'd0);
        check("busy_in_frame", 16'(bus.busy), 16'd1);
        for (int i = 0; i < n; i++) begin
            if (i == ena_drop) ena = 1'b0;
            bus.sdi = d[n-1-i];
            repeat (5) @(negedge clk);
            bus.sck = 1'b1;
            repeat (5) @(negedge clk);
            if (n > WIDTH && i == WIDTH) begin
                check("overrun_err", 16'(bus.frame_err), 16'd1);
                check("overrun_busy", 16'(bus.busy), 16'd0);
            end
            if (i == ena_drop) check("ena_drop_busy", 16'(bus.busy), 16'd0);
            bus.sck = 1'b0;
        end
        repeat (5) @(negedge clk);
        if (good) exp_q.push_back(val);
        bus.cs_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("stb_latency_c%0d", k), 16'(bus.load_stb), 16'(good && k == 3));
        end
    endtask

    initial begin
        vecs[0] = '{nbits: 8, data: 16'h00A5, ena_drop: -1, gap: 2, exp_load: 1'b1, exp_err: 1'b0};
        vecs[1] = '{nbits: 5, data: 16'h001F, ena_drop: -1, gap: 2, exp_load: 1'b0, exp_err: 1'b1};
        vecs[2] = '{nbits: 9, data: 16'h0079, ena_drop: -1, gap: 2, exp_load: 1'b0, exp_err: 1'b1};
        vecs[3] = '{nbits: 8, data: 16'h0001, ena_drop: -1, gap: 4, exp_load: 1'b1, exp_err: 1'b0};
        vecs[4] = '{nbits: 8, data: 16'h0000, ena_drop: -1, gap: 0, exp_load: 1'b1, exp_err: 1'b0};
        vecs[5] = '{nbits: 8, data: 16'h00FF, ena_drop: -1, gap: 2, exp_load: 1'b1, exp_err: 1'b0};
        vecs[6] = '{nbits: 8, data: 16'h0077, ena_drop:  4, gap: 2, exp_load: 1'b0, exp_err: 1'b0};

        rst_n    = 1'b0;
        ena      = 1'b1;
        bus.sck  = 1'b0;
        bus.sdi  = 1'b0;
        bus.cs_n = 1'b1;
        exp_lv   = '0;
        repeat (3) @(negedge clk);
        check("rst_load_val", 16'(bus.load_val), 16'd0);
        check("rst_load_stb", 16'(bus.load_stb), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_frame_err", 16'(bus.frame_err), 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].nbits, vecs[v].data, vecs[v].ena_drop,
                       vecs[v].exp_load, vecs[v].data[WIDTH-1:0]);
            if (vecs[v].exp_load) exp_lv = vecs[v].data[WIDTH-1:0];
            check($sformatf("v%0d_load_val", v), 16'(bus.load_val), 16'(exp_lv));
            check($sformatf("v%0d_frame_err", v), 16'(bus.frame_err), 16'(vecs[v].exp_err));
            check($sformatf("v%0d_busy", v), 16'(bus.busy), 16'd0);
            ena = 1'b1;
            repeat (vecs[v].gap) @(negedge clk);
        end

        // Reset lands between bits 6 and 7 of a frame
        bus.cs_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.sdi = i[0];
            repeat (5) @(negedge clk);
            bus.sck = 1'b1;
            repeat (5) @(negedge clk);
            bus.sck = 1'b0;
        end
        check("pre_rst_busy", 16'(bus.busy), 16'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_load_val", 16'(bus.load_val), 16'd0);
        check("mid_rst_load_stb", 16'(bus.load_stb), 16'd0);
        check("mid_rst_busy", 16'(bus.busy), 16'd0);
        check("mid_rst_frame_err", 16'(bus.frame_err), 16'd0);
        exp_lv   = '0;
        bus.cs_n = 1'b1;
        bus.sck  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 16'(bus.busy), 16'd0);

        send_frame(8, 16'h0081, -1, 1'b1, 8'h81);
        check("rst_recover_load_val", 16'(bus.load_val), 16'h0081);
        check("rst_recover_frame_err", 16'(bus.frame_err), 16'd0);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ser_load_ctrl.md
Name: ser_load_ctrl

Overview:
- Upstream stage of the 8-bit programmable counter: receives a preload value over a 3-wire serial link (sck, sdi, cs_n) on dedicated inputs.
- Delivers that value to the counter's parallel load port as a one-cycle strobe.
- Synchronises the asynchronous serial pins into clk, assembles MSB-first frames and rejects malformed frames.
- Reports busy/error status for the top level to drive onto uio outputs.

Parameters:
- WIDTH, 8, bits per frame and width of load_val
- SYNC_STAGES, 2, flip-flops in each input synchroniser (min 2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when low, the block is held in IDLE and frames are ignored
- sck  input  1  serial clock, asynchronous to clk; data sampled on rising edge
- sdi  input  1  serial data, MSB first
- cs_n  input  1  frame select, active low
- load_val  output  WIDTH  last accepted preload value
- load_stb  output  1  one-cycle pulse; counter loads load_val when high
- busy  output  1  frame in progress (state SHIFT or HOLD)
- frame_err  output  1  sticky error flag for the last frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: load_val=0, load_stb=0, busy=0, frame_err=0, state=IDLE, bit count=0, shift reg=0, synchroniser FFs=1 for sck/cs_n and 0 for sdi.
- Synchronisation and edge detection:
  - sck, sdi and cs_n each pass through SYNC_STAGES FFs.
  - Edges are detected by comparing the synchronised value with a registered copy.
  - Events: sck_rise, cs_fall, cs_rise.
- States:
  - IDLE: on cs_fall with ena=1 -> SHIFT; clear bit count and frame_err.
  - SHIFT:
    - On sck_rise: shift = {shift[WIDTH-2:0], sdi_sync}, bit count +1.
    - When bit count reaches WIDTH -> HOLD.
    - On cs_rise with bit count < WIDTH: set frame_err -> IDLE, no strobe.
  - HOLD:
    - On sck_rise (extra bit): set frame_err -> ERR.
    - On cs_rise: load_val <= shift, load_stb=1 for exactly one cycle -> IDLE.
  - ERR: wait for cs_rise -> IDLE; no strobe.
- Simultaneous events: if sck_rise and cs_rise are detected in the same cycle, cs_rise wins and that sck edge is discarded.
- Latency:
  - load_stb goes high on the (SYNC_STAGES+1)th clk rising edge after cs_n rises at the pin.
  - load_val changes on the same edge and holds until the next good frame.
- busy is registered: high in SHIFT and HOLD, low otherwise.
- frame_err is sticky until the next cs_fall in IDLE.
- ena low: forces IDLE on the next clk edge and aborts any frame without a strobe; frame_err and load_val are unchanged.
- Reset mid-frame: all state is cleared immediately; the pending frame is lost.
- Bit count width is clog2(WIDTH+1) and saturates at WIDTH; it never wraps.
- Timing constraint: sck high and low phases must each be at least SYNC_STAGES+1 clk periods. Faster sck is unsupported and is not required to be detected.

Test Plan:
- Reset, then frame 0xA5: cs_n low, 8 sck pulses of 10 clk each, cs_n high -> load_val=0xA5, load_stb high exactly 1 cycle, 3 clks after cs_n rise; frame_err=0.
- Short frame: 5 bits of 0xFF, then cs_n high -> no load_stb, load_val keeps 0xA5, frame_err=1, busy=0.
- Overrun: 9 bits, 0x3C followed by 1 -> frame_err=1 on the 9th synchronised edge, no strobe on cs_n rise. A following good frame 0x01 -> frame_err clears at cs_fall, load_val=0x01.
- Back-to-back frames 0x00 then 0xFF, 4 clks apart -> two single-cycle strobes, load_val=0x00 then 0xFF.
- ena dropped during bit 4 of 0x77 -> state IDLE, busy=0, no strobe, load_val unchanged.
- rst_n asserted mid-frame between bits 6 and 7 -> all outputs 0 immediately (asynchronous). A subsequent frame 0x81 loads correctly.
